// File: rtl/sevenseg_pkg.sv
// Shared glyph definitions for the seven-segment scan controller.
// Segment order is {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package sevenseg_pkg;

    // Codes 0..9 are plain decimal digits; the upper codes are letters/symbols.
    typedef enum logic [3:0] {
        GLYPH_C    = 4'd10,
        GLYPH_DASH = 4'd11,
        GLYPH_D    = 4'd12,
        GLYPH_L    = 4'd13,
        GLYPH_E    = 4'd14,
        GLYPH_R    = 4'd15
    } glyph_code_e;

    localparam logic [6:0] GLYPH_BLANK_SEG = 7'h7F;

    function automatic logic [6:0] glyph_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:       s = 7'h40;
            4'd1:       s = 7'h79;
            4'd2:       s = 7'h24;
            4'd3:       s = 7'h30;
            4'd4:       s = 7'h19;
            4'd5:       s = 7'h12;
            4'd6:       s = 7'h02;
            4'd7:       s = 7'h78;
            4'd8:       s = 7'h00;
            4'd9:       s = 7'h10;
            GLYPH_C:    s = 7'h46;
            GLYPH_DASH: s = 7'h3F;
            GLYPH_D:    s = 7'h21;
            GLYPH_L:    s = 7'h47;
            GLYPH_E:    s = 7'h06;
            GLYPH_R:    s = 7'h2F;
            default:    s = GLYPH_BLANK_SEG;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_timebase.sv
// Scan timebase: slot counter, digit index, frame end, blink phase and PWM
// enable. Everything advances on plain clk; no derived clocks.
module sevenseg_timebase
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 65536,
    parameter int BLINK_FRAMES = 64,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    brightness,
    output logic [IW-1:0] idx,
    output logic          slot_start,
    output logic          frame_end,
    output logic          blink_on,
    output logic          pwm_en
);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] slot_cnt;
    logic [BW-1:0] blink_cnt;
    logic          slot_end;

    // SLOT_CYCLES is a power of two, so terminal count is all ones.
    assign slot_end   = &slot_cnt;
    assign frame_end  = slot_end && (idx == IW'(NUM_DIGITS - 1));
    assign slot_start = (slot_cnt == '0);
    // Top four bits of the slot counter split each slot into 16 duty steps.
    assign pwm_en     = (slot_cnt[CW-1 -: 4] <= brightness);

    // Free-running slot counter, digit index and frame-based blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            if (frame_end) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed common-anode seven-segment driver with frame-synchronous
// double buffering, blank/blink masks, PWM brightness and anode dead time.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 65536,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] nums,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    load,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame_done
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] nums;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   blink;
    } disp_buf_t;

    logic [IW-1:0] idx;
    logic          slot_start, frame_end, blink_on, pwm_en;
    disp_buf_t     in_buf, pend, act;
    logic          pend_valid;
    logic [3:0]    cur_code;
    logic          cur_dark;

    sevenseg_timebase #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_tb (
        .clk       (clk),
        .rst       (rst),
        .brightness(brightness),
        .idx       (idx),
        .slot_start(slot_start),
        .frame_end (frame_end),
        .blink_on  (blink_on),
        .pwm_en    (pwm_en)
    );

    assign frame_done = frame_end;
    assign in_buf     = {nums, dp_in, blank_in, blink_in};

    // Pending/active double buffer; active only changes at the frame end.
    // A load on the boundary cycle goes straight to active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '{nums: '0, dp: '0, blank: '1, blink: '0};
            act        <= '{nums: '0, dp: '0, blank: '1, blink: '0};
            pend_valid <= 1'b0;
        end else if (frame_end) begin
            if (load)
                act <= in_buf;
            else if (pend_valid)
                act <= pend;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend       <= in_buf;
            pend_valid <= 1'b1;
        end
    end

    // Current digit's code and whether it must be dark this cycle.
    always_comb begin
        cur_code = act.nums[4*idx +: 4];
        cur_dark = act.blank[idx] | (act.blink[idx] & ~blink_on) | ~pwm_en;
    end

    // Registered pin drivers; the anodes get one dead cycle at slot start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg   <= GLYPH_BLANK_SEG;
            dp    <= 1'b1;
            digit <= '1;
        end else if (cur_dark) begin
            seg   <= GLYPH_BLANK_SEG;
            dp    <= 1'b1;
            digit <= '1;
        end else begin
            seg   <= glyph_decode(cur_code);
            dp    <= ~act.dp[idx];
            digit <= slot_start ? '1 : ~(NUM_DIGITS'(1) << idx);
        end
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display with decimal points. It keeps the existing 4-bit glyph encoding. It adds tear-free frame-synchronous loading, per-digit blank and blink masks, and PWM brightness control. All logic runs in the clk domain; the scan rate comes from a clock-enable tick, not a derived clock.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SLOT_CYCLES, 65536, clk cycles per digit slot; power of two, >=16
BLINK_FRAMES, 64, full frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
nums  in  4*NUM_DIGITS  glyph codes; digit i = nums[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit)
blank_in  in  NUM_DIGITS  1 = digit dark regardless of code
blink_in  in  NUM_DIGITS  1 = digit blinks
load  in  1  strobe: capture nums/dp_in/blank_in/blink_in into pending buffer
brightness  in  4  duty level 0..15, sampled live
seg  out  7  segment cathodes {g..a}, active-low
dp  out  1  decimal point cathode, active-low
digit  out  NUM_DIGITS  anode selects, active-low, one-hot-low or all ones
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset state: seg=7'h7F, dp=1, digit=all ones, frame_done=0. Slot counter, digit index, and blink counter are 0; blink phase is "on". Pending and active buffers hold nums=0, dp=0, blank=all ones, blink=0, pending_valid=0.
- Reset mid-operation acts immediately (async) and discards pending data. After release, the display stays dark until the first load is applied.
- Slot counter: free-running 0..SLOT_CYCLES-1. At terminal count the index advances: idx -> idx+1, and NUM_DIGITS-1 wraps to 0.
- frame_done is asserted on the cycle the index wraps from NUM_DIGITS-1 to 0.
- Load: on a load cycle, the inputs are copied to pending and pending_valid=1. A later load before the frame boundary overwrites pending; last wins.
- Frame boundary (same cycle as frame_done): if pending_valid, pending is copied to active and pending_valid is cleared.
- If load coincides with the boundary, the value being loaded that cycle goes to active directly; it is not deferred a frame.
- Active data never changes mid-frame, so there is no tearing.
- Blink: the blink counter counts frames 0..BLINK_FRAMES-1. At wrap the blink phase toggles.
- PWM: phase_hi = slot counter[MSB:MSB-3]. The digit is enabled iff phase_hi <= brightness, giving a duty of (brightness+1)/16.
- Digit dark condition: active blank[idx], OR (active blink[idx] AND phase off), OR PWM disabled.
- Output registers: seg, dp and digit are registered and reflect idx and slot state with 1-clk latency.
  - When the digit is lit: digit has only bit idx low, seg = glyph(code), dp = ~dp[idx].
  - When dark: digit = all ones, seg = 7'h7F, dp = 1.
- Anode guard: digit is forced to all ones during slot count 0 of each slot (one-cycle dead time against ghosting).
- Glyph table (seg = {g,f,e,d,c,b,a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - 10 'C'=46, 11 '-'=3F, 12 'd'=21, 13 'L'=47, 14 'E'=06, 15 'r'=2F (hex)
- Never more than one digit bit is low at a time.

Decomposition:
- Package sevenseg_pkg: glyph enum/constants (GLYPH_C, GLYPH_DASH, GLYPH_D, GLYPH_L, GLYPH_E, GLYPH_R, GLYPH_BLANK_SEG=7'h7F) and function glyph_decode(4-bit) -> 7-bit.
- One sub-module, sevenseg_timebase: slot counter, digit index, frame_done, blink counter and phase, PWM enable.
- The top level holds the buffers and output registers.

Test Plan:
- Reset, then run with no load, NUM_DIGITS=4, SLOT_CYCLES=16, brightness=15 -> digit stays 4'hF and seg 7'h7F for 3 full frames; frame_done pulses every 64 clk.
- load nums=16'h4321, blank=0, dp=4'b0010 mid-frame -> active unchanged until frame_done.
  - Next frame, the digit 0..3 slots show seg 79,24,30,19.
  - dp=0 only during the digit 1 slot.
- load A then load B in the same frame, plus a load coincident with frame_done -> only B appears, and the coincident value is visible in the very next frame.
- brightness=3, SLOT_CYCLES=64 -> digit is low for exactly 15 clk per slot (phase_hi 0..3, minus the guard cycle); brightness=0 -> 3 clk.
- BLINK_FRAMES=2, blink_in=4'b0001, nums=16'hEEEE -> digit 0 dark on frames 2-3 and 6-7, lit otherwise; digits 1..3 always show 06.
- Assert rst mid-slot after a valid load -> all outputs go to reset values asynchronously, and the display stays dark after release until a new load is applied at a frame boundary.
